io_bridge: RTL and testbench

IO_BRIDGE -- requirements
Module: io_bridge

---
 rtl/io_bridge_if.sv | 37 +++
 rtl/io_bridge.sv | 122 ++++++++++++
 tb/tb_io_bridge.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/io_bridge_if.sv
// Processor-side handshake bundle for io_bridge; the tri-state IO bus stays a plain port.
// Latency: none, this is wiring only. Backpressure: TX_READY/TX_VALID and RX_READY/RX_VALID.
// STAT_CLR only exists when IO_BRIDGE_STATUS_EN is defined.
interface io_bridge_if #(
    parameter int WIDTH = 8
);
    logic             IO_DIR;
    logic             IO_STB;
    logic [WIDTH-1:0] TX_DATA;
    logic             TX_VALID;
    logic             TX_READY;
    logic [WIDTH-1:0] RX_DATA;
    logic             RX_VALID;
    logic             RX_READY;
    logic             TX_FULL;
    logic             OVF;
    logic             UNDF;
`ifdef IO_BRIDGE_STATUS_EN
    logic             STAT_CLR;
`endif

    modport slave (
        input  IO_DIR, IO_STB, TX_READY, RX_DATA, RX_VALID,
`ifdef IO_BRIDGE_STATUS_EN
        input  STAT_CLR,
`endif
        output TX_DATA, TX_VALID, RX_READY, TX_FULL, OVF, UNDF
    );

    modport master (
        output IO_DIR, IO_STB, TX_READY, RX_DATA, RX_VALID,
`ifdef IO_BRIDGE_STATUS_EN
        output STAT_CLR,
`endif
        input  TX_DATA, TX_VALID, RX_READY, TX_FULL, OVF, UNDF
    );
endinterface

// File: rtl/io_bridge.sv
// Processor IO bus bridge: writes go into a TX FIFO and reads come from a one-entry RX hold register.
// Latency: 1 cycle from push to TX_VALID. Backpressure: a push into a full FIFO is dropped unless a pop happens in the same cycle.
// The sticky OVF/UNDF flags and STAT_CLR exist only when IO_BRIDGE_STATUS_EN is defined.
module io_bridge #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    inout  wire  [WIDTH-1:0] IO,
    io_bridge_if.slave       bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;

    logic push_req, push, pop, full, not_empty;
    logic rd_stb, rx_rdy, load;
    logic [WIDTH-1:0] io_out;

    assign not_empty = (cnt_q != '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign push_req  = bus.IO_STB & bus.IO_DIR;
    assign pop       = not_empty & bus.TX_READY;
    assign push      = push_req & (~full | pop);
    assign rd_stb    = bus.IO_STB & ~bus.IO_DIR;
    assign rx_rdy    = ~hold_vld_q | rd_stb;
    assign load      = bus.RX_VALID & rx_rdy;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = IO;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // A fresh load wins over consumption of the previously held byte.
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (load) begin
            hold_d     = bus.RX_DATA;
            hold_vld_d = 1'b1;
        end else if (rd_stb) begin
            hold_vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    // Outputs are forced to their idle values while reset is held, even before the first edge.
    assign bus.TX_VALID = RST & not_empty;
    assign bus.TX_FULL  = RST & full;
    assign bus.TX_DATA  = RST ? mem_q[rd_ptr_q] : '0;
    assign bus.RX_READY = ~RST | rx_rdy;
    assign io_out       = (RST & hold_vld_q) ? hold_q : '0;
    assign IO           = bus.IO_DIR ? 'z : io_out;

`ifdef IO_BRIDGE_STATUS_EN
    logic ovf_q, ovf_d, undf_q, undf_d;
    logic drop, undf_evt;

    assign drop     = push_req & ~push;
    assign undf_evt = rd_stb & ~hold_vld_q;

    always_comb begin
        ovf_d  = drop     | (ovf_q  & ~bus.STAT_CLR);
        undf_d = undf_evt | (undf_q & ~bus.STAT_CLR);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ovf_q  <= 1'b0;
            undf_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            undf_q <= undf_d;
        end
    end

    assign bus.OVF  = ovf_q;
    assign bus.UNDF = undf_q;
`else
    assign bus.OVF  = 1'b0;
    assign bus.UNDF = 1'b0;
`endif
endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: a vector table for FIFO/RX behaviour plus hand sequences for RX_READY, flag clear and reset.
module tb_io_bridge;
`ifdef IO_BRIDGE_STATUS_EN
    localparam logic S = 1'b1;
`else
    localparam logic S = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tb_io;
    wire  [7:0] io_w;
    int         checks = 0;
    int         errors = 0;

    io_bridge_if #(.WIDTH(8)) bus ();

    assign io_w = bus.IO_DIR ? tb_io : 'z;

    io_bridge #(.DEPTH(4), .WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .IO  (io_w),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dir, stb;
        logic [7:0] dval;
        logic       trdy;
        logic [7:0] rxd;
        logic       rxv;
        logic       ev;
        logic [7:0] ed;
        logic       ef, eo, eu;
        logic [7:0] eio;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic dir, input logic stb, input logic [7:0] dval,
                                input logic trdy, input logic [7:0] rxd, input logic rxv,
                                input logic ev, input logic [7:0] ed, input logic ef,
                                input logic eo, input logic eu, input logic [7:0] eio);
        vec_t r;
        r.dir = dir; r.stb = stb; r.dval = dval; r.trdy = trdy; r.rxd = rxd; r.rxv = rxv;
        r.ev = ev; r.ed = ed; r.ef = ef; r.eo = eo; r.eu = eu; r.eio = eio;
        return r;
    endfunction

    task automatic drive(input logic dir, input logic stb, input logic [7:0] dval,
                         input logic trdy, input logic [7:0] rxd, input logic rxv);
        bus.IO_DIR   = dir;
        bus.IO_STB   = stb;
        tb_io        = dval;
        bus.TX_READY = trdy;
        bus.RX_DATA  = rxd;
        bus.RX_VALID = rxv;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          dir  stb  dval   trdy rxd    rxv  ev   ed     ef   eo   eu   eio
        vt[0]  = mk(1'b1,1'b1,8'h11,1'b0,8'h00,1'b0,1'b1,8'h11,1'b0,1'b0,1'b0,8'h00);
        vt[1]  = mk(1'b1,1'b1,8'h22,1'b0,8'h00,1'b0,1'b1,8'h11,1'b0,1'b0,1'b0,8'h00);
        vt[2]  = mk(1'b1,1'b1,8'h33,1'b0,8'h00,1'b0,1'b1,8'h11,1'b0,1'b0,1'b0,8'h00);
        vt[3]  = mk(1'b1,1'b1,8'h44,1'b0,8'h00,1'b0,1'b1,8'h11,1'b1,1'b0,1'b0,8'h00);
        vt[4]  = mk(1'b1,1'b1,8'h55,1'b1,8'h00,1'b0,1'b1,8'h22,1'b1,1'b0,1'b0,8'h00);
        vt[5]  = mk(1'b1,1'b1,8'h66,1'b0,8'h00,1'b0,1'b1,8'h22,1'b1,S,   1'b0,8'h00);
        vt[6]  = mk(1'b1,1'b0,8'h00,1'b1,8'h00,1'b0,1'b1,8'h33,1'b0,S,   1'b0,8'h00);
        vt[7]  = mk(1'b1,1'b0,8'h00,1'b1,8'h00,1'b0,1'b1,8'h44,1'b0,S,   1'b0,8'h00);
        vt[8]  = mk(1'b1,1'b0,8'h00,1'b1,8'h00,1'b0,1'b1,8'h55,1'b0,S,   1'b0,8'h00);
        vt[9]  = mk(1'b1,1'b0,8'h00,1'b1,8'h00,1'b0,1'b0,8'h00,1'b0,S,   1'b0,8'h00);
        vt[10] = mk(1'b1,1'b1,8'h77,1'b1,8'h00,1'b0,1'b1,8'h77,1'b0,S,   1'b0,8'h00);
        vt[11] = mk(1'b1,1'b0,8'h00,1'b1,8'h00,1'b0,1'b0,8'h00,1'b0,S,   1'b0,8'h00);
        vt[12] = mk(1'b0,1'b1,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,S,   S,   8'h00);
        vt[13] = mk(1'b0,1'b0,8'h00,1'b0,8'h7E,1'b1,1'b0,8'h00,1'b0,S,   S,   8'h7E);
        vt[14] = mk(1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,S,   S,   8'h7E);
        vt[15] = mk(1'b0,1'b1,8'h00,1'b0,8'h81,1'b1,1'b0,8'h00,1'b0,S,   S,   8'h81);
        vt[16] = mk(1'b0,1'b1,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,S,   S,   8'h00);

        rst = 1'b0;
`ifdef IO_BRIDGE_STATUS_EN
        bus.STAT_CLR = 1'b0;
`endif
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        #1;
        chk("rst_tx_valid", bus.TX_VALID, 1'b0);
        chk("rst_tx_full",  bus.TX_FULL,  1'b0);
        chk("rst_rx_ready", bus.RX_READY, 1'b1);
        chk("rst_tx_data",  bus.TX_DATA,  8'h00);
        chk("rst_io",       io_w,         8'h00);
        tick;
        chk("rst_ovf",  bus.OVF,  1'b0);
        chk("rst_undf", bus.UNDF, 1'b0);
        tick;
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].dir, vt[i].stb, vt[i].dval, vt[i].trdy, vt[i].rxd, vt[i].rxv);
            tick;
            chk($sformatf("v%0d_tx_valid", i), bus.TX_VALID, vt[i].ev);
            if (vt[i].ev) chk($sformatf("v%0d_tx_data", i), bus.TX_DATA, vt[i].ed);
            chk($sformatf("v%0d_tx_full", i), bus.TX_FULL, vt[i].ef);
            chk($sformatf("v%0d_ovf", i), bus.OVF, vt[i].eo);
            chk($sformatf("v%0d_undf", i), bus.UNDF, vt[i].eu);
            if (!vt[i].dir) chk($sformatf("v%0d_io", i), io_w, vt[i].eio);
        end

        // RX_READY: low while holding, raised combinationally by a read strobe.
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'hC3, 1'b1);
        tick;
        chk("hold_rx_ready_busy", bus.RX_READY, 1'b0);
        chk("hold_io_c3",         io_w,         8'hC3);
        drive(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        #1;
        chk("hold_rx_ready_stb",  bus.RX_READY, 1'b1);
        tick;
        chk("hold_io_consumed",   io_w,         8'h00);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        #1;
        chk("hold_rx_ready_empty", bus.RX_READY, 1'b1);

        // Flag clear: a set in the same cycle beats STAT_CLR.
`ifdef IO_BRIDGE_STATUS_EN
        bus.STAT_CLR = 1'b1;
`endif
        drive(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        tick;
        chk("clr_ovf",       bus.OVF,  1'b0);
        chk("clr_undf_wins", bus.UNDF, S);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick;
        chk("clr_undf", bus.UNDF, 1'b0);
`ifdef IO_BRIDGE_STATUS_EN
        bus.STAT_CLR = 1'b0;
`endif

        // Reset in the middle of traffic discards everything.
        drive(1'b1, 1'b1, 8'hA0, 1'b0, 8'h5A, 1'b1);
        tick;
        drive(1'b1, 1'b1, 8'hA1, 1'b0, 8'h00, 1'b0);
        tick;
        chk("pre_rst_tx_valid", bus.TX_VALID, 1'b1);
        chk("pre_rst_tx_data",  bus.TX_DATA,  8'hA0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 8'hA2, 1'b1, 8'h66, 1'b1);
        tick;
        chk("mid_rst_tx_valid", bus.TX_VALID, 1'b0);
        chk("mid_rst_tx_full",  bus.TX_FULL,  1'b0);
        chk("mid_rst_rx_ready", bus.RX_READY, 1'b1);
        chk("mid_rst_tx_data",  bus.TX_DATA,  8'h00);
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick;
        chk("post_rst_tx_valid", bus.TX_VALID, 1'b0);
        chk("post_rst_io",       io_w,         8'h00);
        chk("post_rst_rx_ready", bus.RX_READY, 1'b1);
        chk("post_rst_ovf",      bus.OVF,      1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
